// File: rtl/tx_frame_fifo.sv
// rtl/tx_frame_fifo.sv - store-and-forward TX frame buffer with commit/rollback
module tx_frame_fifo #(
  parameter int DW        = 40,
  parameter int AW        = 11,
  parameter int AF_THRESH = 1984
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_eof,
  input  logic          wr_abort,
  output logic          full,
  output logic          almost_full,
  output logic          drop,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_eof,
  output logic          frame_avail,
  output logic [AW:0]   frame_cnt,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} wstate_t;

  wstate_t        state_q;
  logic [AW:0]    wp_q;
  logic [AW:0]    cp_q;
  logic [AW:0]    rp_q;
  logic [AW:0]    frame_cnt_q;
  logic [DW-1:0]  rd_data_q;
  logic           rd_valid_q;
  logic           rd_eof_q;
  logic           drop_q;

  logic [DW:0]    mem [DEPTH];
  // Separate copy of the end-of-frame tags so the frame count can be
  // decremented at read issue without waiting for the RAM read.
  logic           eof_tag [DEPTH];

  logic [AW:0]    level_d;
  logic           full_d;
  logic           empty_d;
  logic           accept_d;
  logic           commit_d;
  logic           rd_issue_d;
  logic           rd_eof_issue_d;

  assign level_d        = wp_q - rp_q;
  assign full_d         = (level_d == (AW+1)'(DEPTH));
  assign empty_d        = (rp_q == cp_q);
  assign accept_d       = wr_en & ~full_d & (state_q != DROP);
  assign commit_d       = accept_d & wr_eof & ~wr_abort;
  assign rd_issue_d     = rd_en & ~empty_d;
  assign rd_eof_issue_d = rd_issue_d & eof_tag[rp_q[AW-1:0]];

  assign level       = level_d;
  assign full        = full_d;
  assign almost_full = (level_d >= (AW+1)'(AF_THRESH));
  assign frame_cnt   = frame_cnt_q;
  assign frame_avail = (frame_cnt_q != '0);
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_eof      = rd_eof_q;
  assign drop        = drop_q;

  // RAM write port: store tagged word at the write pointer on every accepted write
  always_ff @(posedge clk) begin
    if (accept_d) begin
      mem[wp_q[AW-1:0]]     <= {wr_eof, wr_data};
      eof_tag[wp_q[AW-1:0]] <= wr_eof;
    end
  end

  // Write FSM: advance wp, commit on eof, roll wp back to cp on abort/overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      cp_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (wr_abort) begin
        wp_q    <= cp_q;
        drop_q  <= 1'b1;
        state_q <= IDLE;
      end else if (state_q == DROP) begin
        if (wr_en && wr_eof) begin
          wp_q    <= cp_q;
          drop_q  <= 1'b1;
          state_q <= IDLE;
        end
      end else if (wr_en && full_d) begin
        // Overflowing word; an eof here ends the frame right away.
        if (wr_eof) begin
          wp_q    <= cp_q;
          drop_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          state_q <= DROP;
        end
      end else if (wr_en) begin
        wp_q <= wp_q + 1'b1;
        if (wr_eof) begin
          cp_q    <= wp_q + 1'b1;
          state_q <= IDLE;
        end else begin
          state_q <= IN_FRAME;
        end
      end
    end
  end

  // Read port: one-cycle latency, data held when no read is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp_q       <= '0;
      rd_data_q  <= '0;
      rd_eof_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue_d;
      if (rd_issue_d) begin
        rp_q      <= rp_q + 1'b1;
        rd_data_q <= mem[rp_q[AW-1:0]][DW-1:0];
        rd_eof_q  <= mem[rp_q[AW-1:0]][DW];
      end
    end
  end

  // Frame counter: up on commit, down when an eof-tagged word is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      case ({commit_d, rd_eof_issue_d})
        2'b10:   frame_cnt_q <= frame_cnt_q + 1'b1;
        2'b01:   frame_cnt_q <= frame_cnt_q - 1'b1;
        default: frame_cnt_q <= frame_cnt_q;
      endcase
    end
  end

endmodule
